// File: rtl/sched_pkg.sv
// Shared types and constants for the lane grant scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    SELECT  = 2'd1,
    GRANT   = 2'd2,
    CLEAR   = 2'd3
  } sched_state_e;

  localparam logic [1:0] LANE_N = 2'd0;
  localparam logic [1:0] LANE_E = 2'd1;
  localparam logic [1:0] LANE_S = 2'd2;
  localparam logic [1:0] LANE_W = 2'd3;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned DENS_W    = 2;
  localparam int unsigned HOLD_W    = 16;
  localparam int unsigned SKIP_W    = 3;
  localparam int unsigned SCORE_W   = 3;

  localparam logic [SKIP_W-1:0] SKIP_MAX = '1;

  // Saturating increment for per-lane skip counters.
  function automatic logic [SKIP_W-1:0] skip_inc(input logic [SKIP_W-1:0] s);
    return (s == SKIP_MAX) ? s : s + SKIP_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Highest-score pick among requesting lanes; ties go to the first lane after ptr.
module rr_priority_pick
  import sched_pkg::*;
(
  input  logic [NUM_LANES-1:0][SCORE_W-1:0] scores,
  input  logic [NUM_LANES-1:0]              req,
  input  logic [1:0]                        ptr,
  output logic [1:0]                        sel,
  output logic                              valid
);

  logic [1:0]         lane;
  logic [SCORE_W-1:0] best;

  // Walk lanes in round-robin order; strict '>' keeps the earliest lane on ties.
  always_comb begin
    sel   = ptr;
    valid = 1'b0;
    best  = '0;
    lane  = ptr;
    for (int k = 1; k <= 4; k++) begin
      lane = ptr + 2'(k);
      if (req[lane] && (!valid || scores[lane] > best)) begin
        valid = 1'b1;
        sel   = lane;
        best  = scores[lane];
      end
    end
  end

endmodule

// File: rtl/grant_scheduler.sv
// Sequential lane grant scheduler: all-red, select, timed grant, clear wait.
// Optional pedestrian score boost enabled by GRANT_SCHED_PED_BOOST_EN.
module grant_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned ALL_RED_TIME  = 20,
  parameter int unsigned HOLD_BASE     = 100,
  parameter int unsigned HOLD_STEP     = 50,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned CLEAR_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dens,
  input  logic [3:0] ped_req,
  input  logic [3:0] emergency,
  input  logic [3:0] lane_red,
  output logic [3:0] grant,
  output logic [1:0] active_lane,
  output logic       all_red,
  output logic       preempt,
  output logic       wdog_err
);

  sched_state_e                       state;
  logic [HOLD_W-1:0]                  timer;
  logic [1:0]                         ptr;
  logic [NUM_LANES-1:0][SKIP_W-1:0]   skip;

  logic [NUM_LANES-1:0][DENS_W-1:0]   lane_dens;
  logic [NUM_LANES-1:0][SCORE_W-1:0]  score;
  logic [NUM_LANES-1:0]               req;
  logic                               em_hit, st_hit, rr_valid, pick_valid;
  logic [1:0]                         em_idx, st_idx, rr_idx, pick_idx;
  logic [DENS_W-1:0]                  hold_dens;
  logic [HOLD_W-1:0]                  hold_load;

  // Per-lane request and selection score.
  always_comb begin
    lane_dens = dens;
    for (int i = 0; i < 4; i++) begin
      req[i] = (lane_dens[i] != '0) | ped_req[i] | emergency[i];
`ifdef GRANT_SCHED_PED_BOOST_EN
      score[i] = SCORE_W'(lane_dens[i]) + (ped_req[i] ? SCORE_W'(2) : SCORE_W'(0));
`else
      score[i] = SCORE_W'(lane_dens[i]);
`endif
    end
  end

  // Lowest-index emergency and lowest-index starved requester.
  always_comb begin
    em_hit = 1'b0;
    em_idx = LANE_N;
    st_hit = 1'b0;
    st_idx = LANE_N;
    for (int i = 3; i >= 0; i--) begin
      if (emergency[i]) begin
        em_hit = 1'b1;
        em_idx = 2'(i);
      end
      if (req[i] && skip[i] >= SKIP_W'(STARVE_LIMIT)) begin
        st_hit = 1'b1;
        st_idx = 2'(i);
      end
    end
  end

  rr_priority_pick u_pick (
    .scores (score),
    .req    (req),
    .ptr    (ptr),
    .sel    (rr_idx),
    .valid  (rr_valid)
  );

  // Final pick priority and the hold time it implies.
  always_comb begin
    pick_valid = em_hit | st_hit | rr_valid;
    pick_idx   = em_hit ? em_idx : (st_hit ? st_idx : rr_idx);
`ifdef GRANT_SCHED_PED_BOOST_EN
    hold_dens  = (score[pick_idx] >= SCORE_W'(3)) ? DENS_W'(3) : score[pick_idx][DENS_W-1:0];
`else
    hold_dens  = lane_dens[pick_idx];
`endif
    hold_load  = HOLD_W'(HOLD_BASE + HOLD_STEP * 32'(hold_dens));
  end

  // Scheduler FSM with registered outputs; one shared down-counter per phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALL_RED;
      timer       <= HOLD_W'(ALL_RED_TIME);
      ptr         <= LANE_N;
      skip        <= '0;
      grant       <= '0;
      active_lane <= LANE_N;
      all_red     <= 1'b1;
      preempt     <= 1'b0;
      wdog_err    <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ALL_RED: begin
          if (timer <= HOLD_W'(1)) begin
            state   <= SELECT;
            all_red <= 1'b0;
          end else begin
            timer <= timer - HOLD_W'(1);
          end
        end
        SELECT: begin
          if (pick_valid) begin
            state       <= GRANT;
            grant       <= 4'b0001 << pick_idx;
            active_lane <= pick_idx;
            timer       <= hold_load;
            ptr         <= pick_idx;
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == pick_idx) skip[i] <= '0;
              else if (req[i])       skip[i] <= skip_inc(skip[i]);
            end
          end else begin
            state   <= ALL_RED;
            timer   <= HOLD_W'(1);
            all_red <= 1'b1;
          end
        end
        GRANT: begin
          // An emergency on the granted lane freezes the hold timer.
          if (emergency[active_lane]) begin
            timer <= timer;
          end else if (emergency != '0) begin
            grant   <= '0;
            preempt <= 1'b1;
            state   <= CLEAR;
            timer   <= HOLD_W'(CLEAR_TIMEOUT);
          end else if (timer <= HOLD_W'(1)) begin
            grant <= '0;
            state <= CLEAR;
            timer <= HOLD_W'(CLEAR_TIMEOUT);
          end else begin
            timer <= timer - HOLD_W'(1);
          end
        end
        CLEAR: begin
          if (lane_red[active_lane]) begin
            state   <= ALL_RED;
            timer   <= HOLD_W'(ALL_RED_TIME);
            all_red <= 1'b1;
          end else if (timer <= HOLD_W'(1)) begin
            wdog_err <= 1'b1;
            state    <= ALL_RED;
            timer    <= HOLD_W'(ALL_RED_TIME);
            all_red  <= 1'b1;
          end else begin
            timer <= timer - HOLD_W'(1);
          end
        end
        default: begin
          state   <= ALL_RED;
          timer   <= HOLD_W'(ALL_RED_TIME);
          grant   <= '0;
          all_red <= 1'b1;
        end
      endcase
    end
  end

endmodule
